// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared FSM state, clamp width and kernel-select encoding for the 3x3 Laplacian scheduler
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_e;

    // Headroom bits above PIX_W so that +/-8*max fits in a signed accumulator
    localparam int CLAMP_EXTRA_W = 5;

    typedef enum logic {
        KSEL_8N = 1'b0,
        KSEL_4N = 1'b1
    } ksel_e;

endpackage

// File: rtl/laplacian_kernel_core.sv
// rtl/laplacian_kernel_core.sv - combinational 3x3 Laplacian (8- or 4-neighbour) with clamp to PIX_W
module laplacian_kernel_core
    import conv_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic [2:0][2:0][PIX_W-1:0] win,
    input  ksel_e                      kernel_sel,
    output logic [PIX_W-1:0]           result
);

    localparam int SW = PIX_W + CLAMP_EXTRA_W;
    localparam logic signed [SW-1:0] PIX_MAX = {{CLAMP_EXTRA_W{1'b0}}, {PIX_W{1'b1}}};

    function automatic logic signed [SW-1:0] ext(input logic [PIX_W-1:0] p);
        return $signed({{CLAMP_EXTRA_W{1'b0}}, p});
    endfunction

    logic signed [SW-1:0] cross_sum;
    logic signed [SW-1:0] diag_sum;
    logic signed [SW-1:0] centre;
    logic signed [SW-1:0] acc;

    // win[row][col]: row 0 is the oldest line, col 2 the newest column
    always_comb begin
        cross_sum = ext(win[0][1]) + ext(win[2][1]) + ext(win[1][0]) + ext(win[1][2]);
        diag_sum  = ext(win[0][0]) + ext(win[0][2]) + ext(win[2][0]) + ext(win[2][2]);
        centre    = ext(win[1][1]);
        if (kernel_sel == KSEL_4N) begin
            acc = cross_sum - (centre <<< 2);
        end else begin
            acc = cross_sum + diag_sum - (centre <<< 3);
        end
        result = '0;
        if (acc[SW-1]) begin
            result = '0;
        end else if (acc > PIX_MAX) begin
            result = '1;
        end else begin
            result = acc[PIX_W-1:0];
        end
    end

endmodule

// File: rtl/conv3x3_frame_scheduler.sv
// rtl/conv3x3_frame_scheduler.sv - raster pixel scheduler: line buffers, 3x3 window, FSM, registered result
// LAPLACIAN_SEL_EN adds the kernel_sel input (0 = 8-neighbour, 1 = 4-neighbour).
module conv3x3_frame_scheduler
    import conv_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    input  logic [PIX_W-1:0] in_pixel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [PIX_W-1:0] out_pixel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_done
`ifdef LAPLACIAN_SEL_EN
    ,
    input  logic             kernel_sel
`endif
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    state_e                     state_q, state_d;
    logic [CW-1:0]              col_q, col_d;
    logic [RW-1:0]              row_q, row_d;
    logic [2:0][2:0][PIX_W-1:0] win_q, win_d;
    logic                       out_valid_q, out_valid_d;
    logic [PIX_W-1:0]           out_pixel_q, out_pixel_d;
    logic                       frame_done_q, frame_done_d;

    logic [PIX_W-1:0] lb0_q [IMG_W];
    logic [PIX_W-1:0] lb1_q [IMG_W];

    logic             accept;
    logic             out_fire;
    logic             interior;
    logic             last_pix;
    ksel_e            ksel;
    logic [PIX_W-1:0] kern_res;

`ifdef LAPLACIAN_SEL_EN
    assign ksel = ksel_e'(kernel_sel);
`else
    assign ksel = KSEL_8N;
`endif

    assign in_ready   = (state_q == ST_STREAM) && (!out_valid_q || out_ready);
    assign accept     = in_valid && in_ready;
    assign out_fire   = out_valid_q && out_ready;
    assign interior   = (row_q >= RW'(2)) && (col_q >= CW'(2));
    assign last_pix   = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign busy       = (state_q != ST_IDLE);
    assign out_valid  = out_valid_q;
    assign out_pixel  = out_pixel_q;
    assign frame_done = frame_done_q;

    // Kernel sees the post-shift window so the result lands on the accepting edge
    always_comb begin
        win_d = win_q;
        if (state_q == ST_IDLE && start) begin
            win_d = '0;
        end else if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb1_q[col_q];
            win_d[1][2] = lb0_q[col_q];
            win_d[2][2] = in_pixel;
        end
    end

    laplacian_kernel_core #(
        .PIX_W(PIX_W)
    ) u_core (
        .win       (win_d),
        .kernel_sel(ksel),
        .result    (kern_res)
    );

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        frame_done_d = 1'b0;
        out_valid_d  = out_valid_q && !out_fire;
        out_pixel_d  = out_pixel_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_STREAM;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            ST_STREAM: begin
                if (accept) begin
                    if (last_pix) begin
                        state_d = ST_FLUSH;
                        col_d   = '0;
                        row_d   = '0;
                    end else if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            ST_FLUSH: begin
                if (out_fire) begin
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept && interior) begin
            out_valid_d = 1'b1;
            out_pixel_d = kern_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '0;
            out_valid_q  <= 1'b0;
            out_pixel_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            out_valid_q  <= out_valid_d;
            out_pixel_q  <= out_pixel_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Line buffers hold only pixel history and need no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[col_q] <= lb0_q[col_q];
            lb0_q[col_q] <= in_pixel;
        end
    end

endmodule

// File: tb/tb_conv3x3_frame_scheduler.sv
// tb/tb_conv3x3_frame_scheduler.sv - scoreboard bench for conv3x3_frame_scheduler (8x6 frames)
module tb_conv3x3_frame_scheduler;

    localparam int W    = 8;
    localparam int H    = 6;
    localparam int NRES = (W - 2) * (H - 2);

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy;
    logic [7:0] in_pixel;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_pixel;
    logic       out_valid;
    logic       out_ready;
    logic       frame_done;
`ifdef LAPLACIAN_SEL_EN
    logic       kernel_sel;
`endif

    conv3x3_frame_scheduler #(
        .IMG_W(W),
        .IMG_H(H),
        .PIX_W(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .in_pixel  (in_pixel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_pixel (out_pixel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_done(frame_done)
`ifdef LAPLACIAN_SEL_EN
        ,
        .kernel_sel(kernel_sel)
`endif
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   img[H][W];
    int   exp_q[$];
    int   res_cnt;
    int   mon_e;
    bit   fd_expect;
    bit   fd_seen;
    int   stall_cnt = 0;
    int   or_mode = 0;
    bit   held_v;
    logic [7:0] held_pix;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int lap(input int r, input int c, input bit k4);
        int s;
        s = img[r-1][c] + img[r+1][c] + img[r][c-1] + img[r][c+1];
        if (k4) s = s - 4 * img[r][c];
        else    s = s + img[r-1][c-1] + img[r-1][c+1] + img[r+1][c-1] + img[r+1][c+1] - 8 * img[r][c];
        if (s < 0)   s = 0;
        if (s > 255) s = 255;
        return s;
    endfunction

    always @(posedge clk) begin
        #1;
        if (stall_cnt > 0) begin
            out_ready = 1'b0;
            stall_cnt--;
        end else if (or_mode == 0) begin
            out_ready = 1'b1;
        end else begin
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: handshakes happen on the next rising edge, so sample at the falling edge
    always @(negedge clk) begin
        if (rst) begin
            held_v    = 1'b0;
            fd_expect = 1'b0;
        end else begin
            chk("frame_done", frame_done, fd_expect);
            fd_expect = 1'b0;
            if (frame_done) fd_seen = 1'b1;
            if (held_v && out_valid) chk("held_pixel", out_pixel, held_pix);
            held_v = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %0d expected none", out_pixel);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("result", out_pixel, mon_e);
                    res_cnt++;
                    if (exp_q.size() == 0) fd_expect = 1'b1;
                end
            end else if (out_valid) begin
                chk("in_ready_stall", in_ready, 0);
                held_v   = 1'b1;
                held_pix = out_pixel;
            end
        end
    end

    task automatic run_frame(input int pat, input bit k4, input int gap_pct,
                             input int stall_at, input int abort_at, input int start_at);
        int  idx;
        int  budget;
        bit  acc;
        bit  stalled;
        bit  restarted;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (pat)
                    0:       img[r][c] = 100;
                    1:       img[r][c] = (r == 3 && c == 3) ? 255 : 0;
                    default: img[r][c] = $urandom_range(0, 255);
                endcase
        exp_q.delete();
        for (int r = 1; r < H - 1; r++)
            for (int c = 1; c < W - 1; c++)
                exp_q.push_back(lap(r, c, k4));
        res_cnt = 0;
        fd_seen = 1'b0;
`ifdef LAPLACIAN_SEL_EN
        kernel_sel = k4;
`endif
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("busy_after_start", busy, 1);
        idx = 0;
        budget = 0;
        stalled = 1'b0;
        restarted = 1'b0;
        while (idx < W * H) begin
            if (idx == abort_at) begin
                in_valid = 1'b0;
                rst = 1'b1;
                exp_q.delete();
                @(posedge clk); #1 rst = 1'b0;
                chk("abort_busy", busy, 0);
                chk("abort_out_valid", out_valid, 0);
                repeat (20) @(posedge clk);
                chk("abort_no_frame_done", fd_seen, 0);
                return;
            end
            if (idx == stall_at && !stalled) begin
                stall_cnt = 10;
                stalled = 1'b1;
            end
            if (idx == start_at && !restarted) begin
                start = 1'b1;
                restarted = 1'b1;
            end
            in_valid = ($urandom_range(0, 99) >= gap_pct);
            in_pixel = 8'(img[idx / W][idx % W]);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            start = 1'b0;
            if (acc) idx++;
            budget++;
            if (budget > 5000) begin
                checks++;
                errors++;
                $display("FAIL input_timeout: got %0d pixels expected %0d", idx, W * H);
                break;
            end
        end
        in_valid = 1'b0;
        if (gap_pct == 0 && or_mode == 0 && stall_at < 0)
            chk("throughput_cycles", budget, W * H);
        for (int i = 0; i < 2000 && !fd_seen; i++) @(posedge clk);
        #1;
        chk("frame_done_seen", fd_seen, 1);
        chk("result_count", res_cnt, NRES);
        chk("busy_after_frame", busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_pixel = '0;
        out_ready = 1'b1;
`ifdef LAPLACIAN_SEL_EN
        kernel_sel = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_pixel", out_pixel, 0);
        chk("reset_frame_done", frame_done, 0);

        rst = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        chk("rst_beats_start", busy, 0);

        or_mode = 0;
        run_frame(0, 1'b0, 0, -1, -1, -1);
        run_frame(1, 1'b0, 0, -1, -1, -1);
`ifdef LAPLACIAN_SEL_EN
        run_frame(1, 1'b1, 0, -1, -1, -1);
`endif
        run_frame(2, 1'b0, 0, 30, -1, -1);
        or_mode = 1;
        run_frame(2, 1'b0, 20, 30, -1, -1);
        run_frame(2, 1'b0, 10, -1, 20, -1);
        run_frame(2, 1'b0, 0, -1, -1, -1);
        run_frame(2, 1'b0, 30, -1, -1, 25);
        for (int f = 0; f < 3; f++) begin
`ifdef LAPLACIAN_SEL_EN
            run_frame(2, 1'($urandom_range(0, 1)), 25, -1, -1, -1);
`else
            run_frame(2, 1'b0, 25, -1, -1, -1);
`endif
        end

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
